// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter_if
//  Description : Bundles the requester handshakes, the shared response bus
//                and the external ALU connection of alu_share_arbiter.
//                  slave  : arbiter view (takes requests, drives the ALU)
//                  master : requester/ALU view (testbench or system side)
//                Signals:
//                  reqN_valid/ready, reqN_a/b/op : request handshake + operands
//                  respN_valid/ready             : per-requester response handshake
//                  resp_result/resp_zero         : shared captured result
//                  alu_a/alu_b/alu_control       : to the ALU
//                  alu_result/alu_zero           : from the ALU
//                  busy, resp_drop               : status
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;
    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             busy;
    logic             resp_drop;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_result, resp_zero,
        input  resp0_ready, resp1_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_zero,
        output busy, resp_drop
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_result, resp_zero,
        output resp0_ready, resp1_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_zero,
        input  busy, resp_drop
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Round-robin sequencer sharing one single-cycle ALU between
//                two requesters. One operation in flight: IDLE (grant and
//                latch operands) -> EXEC (drive ALU, capture result) -> RESP
//                (hold result until the owner takes it).
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - alu_share_arbiter_if.slave (requests, responses,
//                        ALU connection, busy / resp_drop status)
//  Options     : define ALU_ARB_TIMEOUT_EN to abandon a response that the
//                owner has not taken within TIMEOUT_CYCLES RESP cycles
//                (resp_drop pulses); otherwise RESP waits indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_share_arbiter_if.slave bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    // The wait counter is 8 bits wide, so the limit has to fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_timeout_range_err
        $error("alu_share_arbiter: TIMEOUT_CYCLES must be in 1..256");
    end

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic w_any_valid;
    logic w_grant;
    logic w_accept;
    logic w_owner_ready;
    logic w_timeout;

    assign w_any_valid   = bus.req0_valid | bus.req1_valid;
    // Contention goes to whoever was not served last; otherwise the lone requester.
    assign w_grant       = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign w_accept      = (state_q == c_st_idle) & w_any_valid;
    // Only the owner's ready matters; the other requester's ready is ignored.
    assign w_owner_ready = owner_q ? bus.resp1_ready : bus.resp0_ready;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       drop_q, drop_d;

    assign w_timeout = (state_q == c_st_resp) & ~w_owner_ready & (wait_cnt_q == c_wait_last);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        // Held at zero outside RESP, so it is already clear on RESP entry.
        if (state_q != c_st_resp) begin
            wait_cnt_d = 8'd0;
        end else if (!w_owner_ready) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        drop_d = w_timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
            drop_q     <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.resp_drop = drop_q;
`else
    assign w_timeout     = 1'b0;
    assign bus.resp_drop = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (w_accept) state_d = c_st_exec;
            c_st_exec: state_d = c_st_resp;
            c_st_resp: if (w_owner_ready || w_timeout) state_d = c_st_idle;
            default:   state_d = c_st_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.resp0_valid = 1'b0;
        bus.resp1_valid = 1'b0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_control = 4'd0;
        bus.busy        = (state_q != c_st_idle);
        case (state_q)
            c_st_idle: begin
                bus.req0_ready = w_any_valid & ~w_grant;
                bus.req1_ready = w_any_valid &  w_grant;
            end
            c_st_exec: begin
                bus.alu_a       = a_q;
                bus.alu_b       = b_q;
                bus.alu_control = op_q;
            end
            c_st_resp: begin
                bus.resp0_valid = ~owner_q;
                bus.resp1_valid =  owner_q;
            end
            default: ;
        endcase
    end

    // ---------------- Operand / result datapath ----------------
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        zero_d       = zero_q;
        if (w_accept) begin
            owner_d      = w_grant;
            last_grant_d = w_grant;
            a_d          = w_grant ? bus.req1_a  : bus.req0_a;
            b_d          = w_grant ? bus.req1_b  : bus.req0_b;
            op_d         = w_grant ? bus.req1_op : bus.req0_op;
        end
        if (state_q == c_st_exec) begin
            result_d = bus.alu_result;
            zero_d   = bus.alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;   // req0 wins the first contention
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 4'd0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;

endmodule
`default_nettype wire
